// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: packed payload, valid/ready handshake,
// synchronous flush to a bubble value, optional two-slot skid buffer that
// makes in_ready_o a flop output.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W      = 32,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
  parameter bit                SKID        = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  generate
    if (SKID) begin : g_skid
      state_e            state_q, state_d;
      logic [DATA_W-1:0] main_q, main_d;
      logic [DATA_W-1:0] skid_q, skid_d;
      logic              in_ready_q;
      logic              in_fire;
      logic              out_fire;

      assign in_fire  = in_valid_i & in_ready_q;
      assign out_fire = (state_q != ST_EMPTY) & out_ready_i;

      // Next-state and slot data; flush overrides every handshake.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_DATA;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (in_fire) begin
                main_d  = in_data_i;
                state_d = ST_ONE;
              end
            end
            ST_ONE: begin
              if (in_fire && out_fire) begin
                main_d = in_data_i;
              end else if (in_fire) begin
                skid_d  = in_data_i;
                state_d = ST_FULL;
              end else if (out_fire) begin
                state_d = ST_EMPTY;
              end
            end
            ST_FULL: begin
              // in_ready is low here, so only the drain path can move.
              if (out_fire) begin
                main_d  = skid_q;
                state_d = ST_ONE;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
      end

      // State, slots and the registered upstream ready.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q    <= ST_EMPTY;
          main_q     <= BUBBLE_DATA;
          skid_q     <= BUBBLE_DATA;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          in_ready_q <= (state_d != ST_FULL);
        end
      end

      assign in_ready_o  = in_ready_q;
      assign out_valid_o = (state_q != ST_EMPTY);
      assign out_data_o  = main_q;
      assign occupancy_o = state_q;
    end else begin : g_noskid
      logic              valid_q, valid_d;
      logic [DATA_W-1:0] main_q, main_d;
      logic              in_ready;
      logic              in_fire;
      logic              out_fire;

      assign in_ready = ~valid_q | out_ready_i;
      assign in_fire  = in_valid_i & in_ready;
      assign out_fire = valid_q & out_ready_i;

      // Single-slot next state; flush overrides every handshake.
      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush_i) begin
          valid_d = 1'b0;
          main_d  = BUBBLE_DATA;
        end else if (in_fire) begin
          valid_d = 1'b1;
          main_d  = in_data_i;
        end else if (out_fire) begin
          valid_d = 1'b0;
        end
      end

      // Main slot register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
          main_q  <= BUBBLE_DATA;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end

      assign in_ready_o  = in_ready;
      assign out_valid_o = valid_q;
      assign out_data_o  = main_q;
      assign occupancy_o = {1'b0, valid_q};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives one SKID=1 and one SKID=0 stage with the same stimulus; each has
// its own scoreboard queue of accepted beats.
module tb_pipe_stage_reg;

  localparam logic [7:0] BUB = 8'h13;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready1, out_valid1, in_ready0, out_valid0;
  logic [7:0] out_data1, out_data0;
  logic [1:0] occ1, occ0;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] q1[$];
  logic [7:0] q0[$];
  logic [7:0] last1 = BUB;
  logic [7:0] last0 = BUB;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(8), .BUBBLE_DATA(BUB), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready1), .in_data_i(in_data),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_data_o(out_data1),
    .occupancy_o(occ1)
  );

  pipe_stage_reg #(.DATA_W(8), .BUBBLE_DATA(BUB), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready0), .in_data_i(in_data),
    .out_valid_o(out_valid0), .out_ready_i(out_ready), .out_data_o(out_data0),
    .occupancy_o(occ0)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // One cycle: drive at the falling edge, check against the model, update
  // the scoreboards with this cycle's fires, then advance to the next
  // falling edge.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    logic ov1, ov0, ir1, ir0;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    ov1 = (q1.size() != 0);
    ov0 = (q0.size() != 0);
    ir1 = (q1.size() < 2);
    ir0 = ~ov0 | ordy;
    chk("s1_valid", 8'(out_valid1), 8'(ov1));
    chk("s1_data",  out_data1, ov1 ? q1[0] : last1);
    chk("s1_occ",   8'(occ1), 8'(q1.size()));
    chk("s1_ready", 8'(in_ready1), 8'(ir1));
    chk("s0_valid", 8'(out_valid0), 8'(ov0));
    chk("s0_data",  out_data0, ov0 ? q0[0] : last0);
    chk("s0_occ",   8'(occ0), 8'(q0.size()));
    chk("s0_ready", 8'(in_ready0), 8'(ir0));
    if (ov1 && ordy) begin
      last1 = q1.pop_front();
      $display("skid1 out beat %h", last1);
    end
    if (ov0 && ordy) begin
      last0 = q0.pop_front();
      $display("skid0 out beat %h", last0);
    end
    if (fl) begin
      q1.delete();
      q0.delete();
      last1 = BUB;
      last0 = BUB;
    end else begin
      if (iv && ir1) q1.push_back(id);
      if (iv && ir0) q0.push_back(id);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_v1"}, 8'(out_valid1), 8'd0);
    chk({tag, "_d1"}, out_data1, BUB);
    chk({tag, "_o1"}, 8'(occ1), 8'd0);
    chk({tag, "_r1"}, 8'(in_ready1), 8'd1);
    chk({tag, "_v0"}, 8'(out_valid0), 8'd0);
    chk({tag, "_d0"}, out_data0, BUB);
    chk({tag, "_o0"}, 8'(occ0), 8'd0);
    chk({tag, "_r0"}, 8'(in_ready0), 8'd1);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #3 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming at full rate.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure fill: A, B held, C stalls.
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("bp_occ_full", 8'(occ1), 8'd2);
    chk("bp_ready_low", 8'(in_ready1), 8'd0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("bp_ready_back", 8'(in_ready1), 8'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush while FULL with D offered in the flush cycle.
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'hDD, 1'b0, 1'b1);
    chk("flush_valid", 8'(out_valid1), 8'd0);
    chk("flush_data",  out_data1, BUB);
    chk("flush_occ",   8'(occ1), 8'd0);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush coinciding with an output fire.
    step(1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'hDE, 1'b1, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Toggle out_ready under a continuous upstream stream.
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + i), i[0], 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset asserted while FULL.
    step(1'b1, 8'h91, 1'b0, 1'b0);
    step(1'b1, 8'h92, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    q1.delete(); q0.delete();
    last1 = BUB; last0 = BUB;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("e_valid", 8'(out_valid1), 8'd1);
    chk("e_data",  out_data1, 8'hEE);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0));
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline stage register: the next-generation replacement for the fixed-payload stage registers between the core's pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary packed payload with a valid/ready handshake, synchronous flush to a configurable bubble value, and an optional skid slot that registers the upstream ready path. Every pipeline boundary instantiates it with its own payload width and bubble value.

## Interface
- DATA_W, default 32: payload width in bits, at least 1.
- BUBBLE_DATA, default '0 (DATA_W bits): payload loaded on reset and flush. For example, a NOP-carrying payload whose instruction field is 32'h00000013.
- SKID, default 1: 1 gives a two-slot skid buffer with registered in_ready_o. 0 gives a single slot with combinational in_ready_o.
- clk  input  1  clock. All state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush_i  input  1  synchronous flush. Discards all held and incoming beats.
- in_valid_i  input  1  upstream beat valid.
- in_ready_o  output  1  stage can accept a beat.
- in_data_i  input  DATA_W  upstream payload.
- out_valid_o  output  1  downstream beat valid.
- out_ready_i  input  1  downstream accepts.
- out_data_o  output  DATA_W  downstream payload, driven from the main slot.
- occupancy_o  output  2  number of held beats, 0..2 (0..1 when SKID=0).

## Operation
- Handshake rules:
  - Input fire = in_valid_i & in_ready_o.
  - Output fire = out_valid_o & out_ready_i.
  - in_data_i is ignored unless in_valid_i is high.
- Output stability: while out_valid_o=1 and out_ready_i=0, out_valid_o and out_data_o hold unchanged until flush or reset.
- When the stage drains to empty, out_data_o keeps its last value. Only reset and flush load BUBBLE_DATA.
- SKID=1 state machine. occupancy_o encodes the state: EMPTY=0, ONE=1, FULL=2. There is a main slot (drives out_*) and a skid slot.
  - in_ready_o = !skid_valid. It is a flop output; there is no combinational path from out_ready_i.
  - EMPTY, on input fire: main <= in_data_i, go to ONE.
  - ONE, input fire and output fire together: main <= in_data_i, stay in ONE.
  - ONE, input fire only: skid <= in_data_i, go to FULL.
  - ONE, output fire only: go to EMPTY.
  - ONE, neither: hold.
  - FULL: in_ready_o = 0. On output fire: main <= skid, go to ONE. Otherwise hold.
- SKID=0:
  - Single main slot.
  - in_ready_o = !out_valid_o | out_ready_i, combinational.
  - On input fire: main <= in_data_i and out_valid_o <= 1.
  - On output fire without input fire: out_valid_o <= 0.
- Flush, which has priority over all handshake activity:
  - Next state: occupancy 0, out_valid_o 0, main data = BUBBLE_DATA, skid valid cleared.
  - A beat presented in the flush cycle is discarded even if in_ready_o was high.
  - An output fire in the flush cycle counts as delivered; downstream treats it as normal.
- Reset, asynchronous and taking effect immediately:
  - out_valid_o = 0, out_data_o = BUBBLE_DATA, occupancy_o = 0, in_ready_o = 1.
  - Skid contents are don't-care, but skid valid = 0.
  - Reset asserted mid-transfer drops all held beats. Operation resumes on the first rising edge after rst deasserts.
- No beat is lost or duplicated except by flush or reset. Order is strictly FIFO.

## Timing
- Latency: input fire at edge N gives out_valid_o=1 with that payload after edge N (visible in cycle N+1).
- Throughput: one beat per cycle sustained when out_ready_i stays high, in both modes.
- SKID=1, backpressure response:
  - Downstream deasserts out_ready_i in cycle C. The stage still accepts the beat offered in C into the skid slot.
  - in_ready_o falls after edge C.
  - in_ready_o rises one cycle after the output fire that empties the skid slot.
- SKID=0: in_ready_o reacts combinationally in the same cycle as out_ready_i.
- flush_i acts at the next rising edge. Outputs read empty/bubble from the following cycle.

## Test plan
- Reset value check, DATA_W=8, BUBBLE_DATA=8'h13:
  - Stimulus: assert rst asynchronously mid-cycle.
  - Required: out_valid_o=0, out_data_o=8'h13, occupancy_o=0, in_ready_o=1 before the next edge.
- Streaming, SKID=1:
  - Stimulus: out_ready_i=1, feed 8'h01..8'h10 on consecutive cycles.
  - Required: same sequence on out_data_o one cycle later, no gaps, occupancy_o stays at 1.
- Backpressure fill, SKID=1:
  - Stimulus: send A, B, C with out_ready_i=0.
  - Required: A and B are held, occupancy_o=2, in_ready_o=0, C stalls upstream.
  - Stimulus: raise out_ready_i.
  - Required: A, B, C are delivered in order and in_ready_o returns to 1.
- Flush while FULL:
  - Stimulus: assert flush_i for one cycle, with in_valid_i=1 carrying D in the same cycle.
  - Required: next cycle out_valid_o=0, out_data_o=BUBBLE_DATA, occupancy_o=0. D is never delivered.
- SKID=0 mode:
  - Stimulus: hold out_valid_o=1, toggle out_ready_i.
  - Required: in_ready_o follows combinationally, occupancy_o never exceeds 1, order is preserved.
- Reset mid-operation:
  - Stimulus: assert rst while FULL, then deassert and send E.
  - Required: no stale beats appear, and E emerges first, one cycle after its input fire.
